// File: rtl/hsi_dist_argmin_if.sv
// hsi_dist_argmin_if
//   Beat stream and result bus of the HSI distance/argmin block.
//   master : drives the beat stream (element_*, library_last, dist_mode,
//            vctr_ref), receives dist_* and best_* results.
//   slave  : the distance engine; consumes beats, drives results.
interface hsi_dist_argmin_if #(
  parameter int WORD_WIDTH       = 32,
  parameter int HSI_LIBRARY_SIZE = 256
);
  localparam int REF_W = $clog2(HSI_LIBRARY_SIZE);

  logic                  element_valid;
  logic                  element_start;
  logic                  element_last;
  logic                  library_last;
  logic                  dist_mode;
  logic [REF_W-1:0]      vctr_ref;
  logic [WORD_WIDTH-1:0] element_a;
  logic [WORD_WIDTH-1:0] element_b;

  logic [WORD_WIDTH-1:0] dist_value;
  logic [REF_W-1:0]      dist_ref;
  logic                  dist_valid;
  logic                  dist_error;
  logic [WORD_WIDTH-1:0] best_value;
  logic [REF_W-1:0]      best_ref;
  logic                  best_valid;

  modport master (
    output element_valid, element_start, element_last, library_last,
           dist_mode, vctr_ref, element_a, element_b,
    input  dist_value, dist_ref, dist_valid, dist_error,
           best_value, best_ref, best_valid
  );

  modport slave (
    input  element_valid, element_start, element_last, library_last,
           dist_mode, vctr_ref, element_a, element_b,
    output dist_value, dist_ref, dist_valid, dist_error,
           best_value, best_ref, best_valid
  );
endinterface

// File: rtl/hsi_dist_argmin.sv
// hsi_dist_argmin
//   Streams packed pixel/reference word pairs through a 3-stage pipeline,
//   producing a per-vector MSE or MAE distance and tracking the minimum
//   distance reference across a library scan.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : slave side of hsi_dist_argmin_if (beat stream in, results out)
module hsi_dist_argmin #(
  parameter int WORD_WIDTH       = 32,
  parameter int DATA_WIDTH       = 16,
  parameter int DATA_WIDTH_MUL   = 32,
  parameter int DATA_WIDTH_ACC   = 48,
  parameter int HSI_BANDS        = 128,
  parameter int HSI_LIBRARY_SIZE = 256
) (
  input  logic               clk,
  input  logic               rst_n,
  hsi_dist_argmin_if.slave   bus
);
  localparam int DATA_PER_WORD = WORD_WIDTH / DATA_WIDTH;
  localparam int ELEMENTS      = HSI_BANDS / DATA_PER_WORD;
  localparam int REF_W         = $clog2(HSI_LIBRARY_SIZE);
  localparam int SHIFT         = $clog2(HSI_BANDS);
  // One spare bit so an over-long vector can never wrap back to ELEMENTS.
  localparam int CNT_W         = $clog2(ELEMENTS + 1) + 1;
  localparam int SUM_W         = DATA_WIDTH_ACC + 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ELEM = CNT_W'(ELEMENTS);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  // ---------------- beat qualification / vector FSM ----------------
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic [REF_W-1:0] ref_q, ref_d;
  logic             beat_start, beat_acc, beat_fin, beat_err;

  always_comb begin
    beat_start = bus.element_valid & bus.element_start;
    beat_acc   = beat_start | (bus.element_valid & (state_q == ST_ACTIVE));
    beat_fin   = beat_acc & bus.element_last;
    state_d    = state_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    ref_d      = ref_q;
    if (beat_start) begin
      cnt_d  = CNT_W'(1);
      mode_d = bus.dist_mode;
      ref_d  = bus.vctr_ref;
    end else if (beat_acc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (beat_fin)        state_d = ST_IDLE;
    else if (beat_start) state_d = ST_ACTIVE;
    beat_err = (cnt_d != CNT_ELEM);
  end

  // ---------------- per-lane datapath ----------------
  logic [DATA_PER_WORD*DATA_WIDTH-1:0]     abs_d, abs1_q;
  logic [DATA_PER_WORD*DATA_WIDTH_MUL-1:0] term_d, term2_q;
  logic                                    mode1_q;

  generate
    for (genvar gi = 0; gi < DATA_PER_WORD; gi++) begin : g_lane
      logic [DATA_WIDTH-1:0]     lane_a, lane_b, lane_abs;
      logic [DATA_WIDTH_MUL-1:0] lane_ext;
      assign lane_a   = bus.element_a[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_b   = bus.element_b[gi*DATA_WIDTH +: DATA_WIDTH];
      assign abs_d[gi*DATA_WIDTH +: DATA_WIDTH] =
        (lane_a >= lane_b) ? (lane_a - lane_b) : (lane_b - lane_a);
      assign lane_abs = abs1_q[gi*DATA_WIDTH +: DATA_WIDTH];
      assign lane_ext = DATA_WIDTH_MUL'(lane_abs);
      assign term_d[gi*DATA_WIDTH_MUL +: DATA_WIDTH_MUL] =
        mode1_q ? lane_ext : (lane_ext * lane_ext);
    end
  endgenerate

  // ---------------- pipeline control ----------------
  logic             v1_q, start1_q, fin1_q, err1_q, lib1_q;
  logic [REF_W-1:0] ref1_q;
  logic             v2_q, start2_q, fin2_q, err2_q, lib2_q;
  logic [REF_W-1:0] ref2_q;
  logic             fin3_q, err3_q, lib3_q;
  logic [REF_W-1:0] ref3_q;
  logic [DATA_WIDTH_ACC-1:0] acc_q, acc_d;

  // Lane sum plus accumulate, clamped to all-ones instead of wrapping.
  logic [SUM_W-1:0] lane_sum, acc_sum;
  always_comb begin
    lane_sum = '0;
    for (int i = 0; i < DATA_PER_WORD; i++)
      lane_sum = lane_sum + SUM_W'(term2_q[i*DATA_WIDTH_MUL +: DATA_WIDTH_MUL]);
    acc_sum = (start2_q ? {SUM_W{1'b0}} : {1'b0, acc_q}) + lane_sum;
    acc_d   = acc_sum[SUM_W-1] ? {DATA_WIDTH_ACC{1'b1}} : acc_sum[DATA_WIDTH_ACC-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      ref_q    <= '0;
      v1_q     <= 1'b0; start1_q <= 1'b0; fin1_q <= 1'b0; err1_q <= 1'b0;
      lib1_q   <= 1'b0; mode1_q  <= 1'b0; ref1_q <= '0;   abs1_q <= '0;
      v2_q     <= 1'b0; start2_q <= 1'b0; fin2_q <= 1'b0; err2_q <= 1'b0;
      lib2_q   <= 1'b0; ref2_q   <= '0;   term2_q <= '0;
      fin3_q   <= 1'b0; err3_q   <= 1'b0; lib3_q <= 1'b0; ref3_q <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      ref_q    <= ref_d;
      // S1: absolute differences
      v1_q     <= beat_acc;
      start1_q <= beat_start;
      fin1_q   <= beat_fin;
      err1_q   <= beat_err;
      lib1_q   <= bus.library_last;
      mode1_q  <= mode_d;
      ref1_q   <= ref_d;
      abs1_q   <= abs_d;
      // S2: square or pass-through
      v2_q     <= v1_q;
      start2_q <= start1_q;
      fin2_q   <= v1_q & fin1_q;
      err2_q   <= err1_q;
      lib2_q   <= lib1_q;
      ref2_q   <= ref1_q;
      term2_q  <= term_d;
      // S3: accumulate
      if (v2_q) acc_q <= acc_d;
      fin3_q   <= v2_q & fin2_q;
      err3_q   <= err2_q;
      lib3_q   <= lib2_q;
      ref3_q   <= ref2_q;
    end
  end

  // ---------------- result and argmin ----------------
  logic [DATA_WIDTH_ACC-1:0] acc_shr;
  logic [WORD_WIDTH-1:0]     result;
  assign acc_shr = acc_q >> SHIFT;
  assign result  = (|acc_shr[DATA_WIDTH_ACC-1:WORD_WIDTH]) ? {WORD_WIDTH{1'b1}}
                                                           : acc_shr[WORD_WIDTH-1:0];

  logic                  scan_have_q;
  logic [WORD_WIDTH-1:0] scan_val_q;
  logic [REF_W-1:0]      scan_ref_q;
  logic                  take, have_n;
  logic [WORD_WIDTH-1:0] val_n;
  logic [REF_W-1:0]      ref_n;

  // Strict less-than so ties keep the earlier reference.
  always_comb begin
    take   = !err3_q && (!scan_have_q || (result < scan_val_q));
    have_n = scan_have_q | take;
    val_n  = take ? result : scan_val_q;
    ref_n  = take ? ref3_q : scan_ref_q;
  end

  logic                  dist_valid_q, dist_error_q, best_valid_q;
  logic [WORD_WIDTH-1:0] dist_value_q, best_value_q;
  logic [REF_W-1:0]      dist_ref_q, best_ref_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_valid_q <= 1'b0; dist_error_q <= 1'b0; best_valid_q <= 1'b0;
      dist_value_q <= '0;   dist_ref_q   <= '0;
      best_value_q <= '0;   best_ref_q   <= '0;
      scan_have_q  <= 1'b0; scan_val_q   <= '0;   scan_ref_q <= '0;
    end else begin
      dist_valid_q <= fin3_q;
      best_valid_q <= fin3_q & lib3_q;
      if (fin3_q) begin
        dist_value_q <= result;
        dist_ref_q   <= ref3_q;
        dist_error_q <= err3_q;
        if (lib3_q) begin
          // A scan with no good vector reports all-ones at reference 0.
          best_value_q <= have_n ? val_n : {WORD_WIDTH{1'b1}};
          best_ref_q   <= have_n ? ref_n : '0;
          scan_have_q  <= 1'b0;
        end else begin
          scan_have_q  <= have_n;
          scan_val_q   <= val_n;
          scan_ref_q   <= ref_n;
        end
      end
    end
  end

  assign bus.dist_value = dist_value_q;
  assign bus.dist_ref   = dist_ref_q;
  assign bus.dist_valid = dist_valid_q;
  assign bus.dist_error = dist_error_q;
  assign bus.best_value = best_value_q;
  assign bus.best_ref   = best_ref_q;
  assign bus.best_valid = best_valid_q;
endmodule
